// File: rtl/regfile_pkg.sv
// Shared types and the per-address write-port select helper for the multi-ported register file.
package regfile_pkg;

   localparam int DEF_N  = 32;
   localparam int DEF_W  = 32;
   localparam int DEF_AW = $clog2(DEF_N);
   localparam int MAX_NW = 4;
   localparam int PW     = 2;

   typedef logic [DEF_AW-1:0] addr_t;
   typedef logic [DEF_W-1:0]  data_t;

   typedef struct packed {
      logic          hit;
      logic          multi;
      logic [PW-1:0] port;
   } wsel_t;

   // match[j] = port j writes this address; the highest matching port wins.
   // Result is all-zero when nothing matches.
   function automatic wsel_t wsel(input logic [MAX_NW-1:0] match);
      wsel_t s;
      s = '0;
      for (int j = 0; j < MAX_NW; j++) begin
         if (match[j]) begin
            if (s.hit) s.multi = 1'b1;
            s.hit  = 1'b1;
            s.port = PW'(j);
         end
      end
      return s;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: writebacks release, issue reserves, reserve beats release on the same edge.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int N  = DEF_N,
   parameter  int NW = 1,
   localparam int AW = $clog2(N)
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NW-1:0]         wen,
   input  logic [NW-1:0][AW-1:0] waddr,
   input  logic                  iss_valid,
   input  logic [AW-1:0]         iss_rd,
   output logic [N-1:0]          busy,
   output logic                  iss_stall
);

   logic [N-1:1]      bsy;
   logic [N-1:1]      rel;
   logic [N-1:0]      rel_full;
   logic              rsv;
   logic [MAX_NW-1:0] m;

   always_comb begin
      rel = '0;
      m   = '0;
      for (int a = 1; a < N; a++) begin
         m = '0;
         for (int j = 0; j < NW; j++) m[j] = wen[j] && (waddr[j] == AW'(a));
         rel[a] = (wsel(m) != '0);
      end
   end

   assign busy      = {bsy, 1'b0};
   assign rel_full  = {rel, 1'b0};
   assign iss_stall = iss_valid && (iss_rd != '0) && busy[iss_rd] && !rel_full[iss_rd];
   assign rsv       = iss_valid && !iss_stall && (iss_rd != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bsy <= '0;
      end else begin
         for (int a = 1; a < N; a++) begin
            if (rsv && (iss_rd == AW'(a))) bsy[a] <= 1'b1;
            else if (rel[a])               bsy[a] <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with hardwired-zero r0 and integrated writeback scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int N  = DEF_N,
   parameter  int W  = DEF_W,
   parameter  int NR = 2,
   parameter  int NW = 1,
   localparam int AW = $clog2(N)
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NW-1:0]         wen,
   input  logic [NW-1:0][AW-1:0] waddr,
   input  logic [NW-1:0][W-1:0]  wdata,
   input  logic [NR-1:0][AW-1:0] raddr,
   output logic [NR-1:0][W-1:0]  rdata,
   output logic [NR-1:0]         rbusy,
   input  logic                  iss_valid,
   input  logic [AW-1:0]         iss_rd,
   output logic                  iss_stall,
   output logic                  err_wconflict
);

   logic [W-1:0]      regs  [N-1:1];
   logic [W-1:0]      rview [N-1:0];
   logic [N-1:1]      whit;
   logic [N-1:1]      wmulti;
   logic [W-1:0]      wval  [N-1:1];
   logic [N-1:0]      busy;
   logic [MAX_NW-1:0] m;
   wsel_t             s;

   // Per-address winning write port and its data
   always_comb begin
      whit   = '0;
      wmulti = '0;
      m      = '0;
      s      = '0;
      for (int a = 1; a < N; a++) begin
         m = '0;
         for (int j = 0; j < NW; j++) m[j] = wen[j] && (waddr[j] == AW'(a));
         s         = wsel(m);
         whit[a]   = s.hit;
         wmulti[a] = s.multi;
         wval[a]   = '0;
         for (int j = 0; j < NW; j++) begin
            if (s.port == PW'(j)) wval[a] = wdata[j];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int a = 1; a < N; a++) regs[a] <= '0;
      end else begin
         for (int a = 1; a < N; a++) begin
            if (whit[a]) regs[a] <= wval[a];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       err_wconflict <= 1'b0;
      else if (|wmulti) err_wconflict <= 1'b1;
   end

   regfile_scoreboard #(
      .N  (N),
      .NW (NW)
   ) u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .wen       (wen),
      .waddr     (waddr),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .busy      (busy),
      .iss_stall (iss_stall)
   );

   always_comb begin
      rview[0] = '0;
      for (int a = 1; a < N; a++) rview[a] = regs[a];
   end

`ifdef REGFILE_BYPASS_EN
   logic [N-1:0] byp_hit;
   logic [W-1:0] byp_val [N-1:0];

   always_comb begin
      byp_hit    = {whit, 1'b0};
      byp_val[0] = '0;
      for (int a = 1; a < N; a++) byp_val[a] = wval[a];
   end

   always_comb begin
      rdata = '0;
      rbusy = '0;
      for (int i = 0; i < NR; i++) begin
         if (byp_hit[raddr[i]]) begin
            rdata[i] = byp_val[raddr[i]];
            rbusy[i] = 1'b0;
         end else begin
            rdata[i] = rview[raddr[i]];
            rbusy[i] = busy[raddr[i]];
         end
      end
   end
`else
   always_comb begin
      rdata = '0;
      rbusy = '0;
      for (int i = 0; i < NR; i++) begin
         rdata[i] = rview[raddr[i]];
         rbusy[i] = busy[raddr[i]];
      end
   end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (NW=2, NR=2): vector table plus conflict, bypass and async-reset sequences.
module tb_regfile_mp;

   localparam int N  = 32;
   localparam int W  = 32;
   localparam int NR = 2;
   localparam int NW = 2;
   localparam int AW = 5;

   logic                  clk;
   logic                  rst_n;
   logic [NW-1:0]         wen;
   logic [NW-1:0][AW-1:0] waddr;
   logic [NW-1:0][W-1:0]  wdata;
   logic [NR-1:0][AW-1:0] raddr;
   logic [NR-1:0][W-1:0]  rdata;
   logic [NR-1:0]         rbusy;
   logic                  iss_valid;
   logic [AW-1:0]         iss_rd;
   logic                  iss_stall;
   logic                  err_wconflict;

   int checks = 0;
   int errors = 0;

   regfile_mp #(.N(N), .W(W), .NR(NR), .NW(NW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wen           (wen),
      .waddr         (waddr),
      .wdata         (wdata),
      .raddr         (raddr),
      .rdata         (rdata),
      .rbusy         (rbusy),
      .iss_valid     (iss_valid),
      .iss_rd        (iss_rd),
      .iss_stall     (iss_stall),
      .err_wconflict (err_wconflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  wen;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic        iv;
      logic [4:0]  ird;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [1:0]  eb;
      logic        es;
   } vec_t;

   localparam int NV = 15;
   vec_t tbl [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      wen       = '0;
      waddr     = '0;
      wdata     = '0;
      iss_valid = 1'b0;
      iss_rd    = '0;
   endtask

   initial begin
      // pre-edge expectations: each row sees the state left by the rows before it
      tbl[0]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        5'd0, 5'd31, 1'b0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b0};
      tbl[1]  = '{2'b01, 5'd1, 32'hA5A5A5A5, 5'd0, 32'h0,        5'd1, 5'd2,  1'b0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b0};
      tbl[2]  = '{2'b01, 5'd2, 32'h5A5A5A5A, 5'd0, 32'h0,        5'd1, 5'd5,  1'b0, 5'd0, 32'hA5A5A5A5, 32'h0,        2'b00, 1'b0};
      tbl[3]  = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,        5'd2, 5'd1,  1'b0, 5'd0, 32'h5A5A5A5A, 32'hA5A5A5A5, 2'b00, 1'b0};
      tbl[4]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        5'd0, 5'd2,  1'b0, 5'd0, 32'h0,        32'h5A5A5A5A, 2'b00, 1'b0};
      tbl[5]  = '{2'b10, 5'd0, 32'h0,        5'd9, 32'h0BADF00D, 5'd1, 5'd0,  1'b0, 5'd0, 32'hA5A5A5A5, 32'h0,        2'b00, 1'b0};
      tbl[6]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        5'd7, 5'd9,  1'b1, 5'd7, 32'h0,        32'h0BADF00D, 2'b00, 1'b0};
      tbl[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        5'd7, 5'd1,  1'b1, 5'd7, 32'h0,        32'hA5A5A5A5, 2'b01, 1'b1};
      tbl[8]  = '{2'b01, 5'd7, 32'h00000077, 5'd0, 32'h0,        5'd0, 5'd1,  1'b1, 5'd7, 32'h0,        32'hA5A5A5A5, 2'b00, 1'b0};
      tbl[9]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        5'd7, 5'd7,  1'b0, 5'd0, 32'h00000077, 32'h00000077, 2'b11, 1'b0};
      tbl[10] = '{2'b10, 5'd0, 32'h0,        5'd7, 32'h12345678, 5'd0, 5'd9,  1'b1, 5'd0, 32'h0,        32'h0BADF00D, 2'b00, 1'b0};
      tbl[11] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        5'd7, 5'd1,  1'b1, 5'd7, 32'h12345678, 32'hA5A5A5A5, 2'b00, 1'b0};
      tbl[12] = '{2'b10, 5'd0, 32'h0,        5'd7, 32'hCAFEF00D, 5'd9, 5'd2,  1'b1, 5'd7, 32'h0BADF00D, 32'h5A5A5A5A, 2'b00, 1'b0};
      tbl[13] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        5'd7, 5'd9,  1'b0, 5'd0, 32'hCAFEF00D, 32'h0BADF00D, 2'b01, 1'b0};
      tbl[14] = '{2'b01, 5'd9, 32'h0,        5'd0, 32'h0,        5'd7, 5'd0,  1'b1, 5'd7, 32'hCAFEF00D, 32'h0,        2'b01, 1'b1};

      rst_n = 1'b0;
      idle();
      raddr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // reset state on every address, both ports
      for (int a = 0; a < N; a++) begin
         raddr[0] = AW'(a);
         raddr[1] = AW'(N - 1 - a);
         #1;
         chk($sformatf("rst_rdata0_a%0d", a), rdata[0], 32'h0);
         chk($sformatf("rst_rdata1_a%0d", a), rdata[1], 32'h0);
         chk($sformatf("rst_rbusy_a%0d", a), {30'b0, rbusy}, 32'h0);
      end
      chk("rst_err", {31'b0, err_wconflict}, 32'h0);

      for (int k = 0; k < NV; k++) begin
         @(negedge clk);
         wen       = tbl[k].wen;
         waddr[0]  = tbl[k].wa0;
         wdata[0]  = tbl[k].wd0;
         waddr[1]  = tbl[k].wa1;
         wdata[1]  = tbl[k].wd1;
         raddr[0]  = tbl[k].ra0;
         raddr[1]  = tbl[k].ra1;
         iss_valid = tbl[k].iv;
         iss_rd    = tbl[k].ird;
         #1;
         chk($sformatf("v%0d_rdata0", k), rdata[0], tbl[k].e0);
         chk($sformatf("v%0d_rdata1", k), rdata[1], tbl[k].e1);
         chk($sformatf("v%0d_rbusy", k), {30'b0, rbusy}, {30'b0, tbl[k].eb});
         chk($sformatf("v%0d_stall", k), {31'b0, iss_stall}, {31'b0, tbl[k].es});
         chk($sformatf("v%0d_err", k), {31'b0, err_wconflict}, 32'h0);
      end

      // both ports to r0: not a conflict
      @(negedge clk);
      idle();
      wen      = 2'b11;
      waddr[0] = 5'd0;
      waddr[1] = 5'd0;
      wdata[0] = 32'h11111111;
      wdata[1] = 32'h22222222;
      @(negedge clk);
      idle();
      #1;
      chk("r0_dual_err", {31'b0, err_wconflict}, 32'h0);

      // both ports to r5: port 1 wins, sticky error
      @(negedge clk);
      wen      = 2'b11;
      waddr[0] = 5'd5;
      waddr[1] = 5'd5;
      wdata[0] = 32'h11111111;
      wdata[1] = 32'h22222222;
      raddr[0] = 5'd1;
      raddr[1] = 5'd7;
      @(negedge clk);
      idle();
      raddr[0] = 5'd5;
      #1;
      chk("conflict_r5", rdata[0], 32'h22222222);
      chk("conflict_err", {31'b0, err_wconflict}, 32'h1);
      repeat (3) @(negedge clk);
      #1;
      chk("conflict_err_held", {31'b0, err_wconflict}, 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      #1;
      chk("pulse_err", {31'b0, err_wconflict}, 32'h0);
      chk("pulse_r5", rdata[0], 32'h0);
      chk("pulse_r7", rdata[1], 32'h0);
      chk("pulse_rbusy", {30'b0, rbusy}, 32'h0);

      // same-cycle write while reading the target
      @(negedge clk);
      iss_valid = 1'b1;
      iss_rd    = 5'd3;
      @(negedge clk);
      idle();
      raddr[0] = 5'd3;
      raddr[1] = 5'd0;
      #1;
      chk("r3_busy", {31'b0, rbusy[0]}, 32'h1);
      @(negedge clk);
      wen      = 2'b01;
      waddr[0] = 5'd3;
      wdata[0] = 32'hDEADBEEF;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("byp_rdata", rdata[0], 32'hDEADBEEF);
      chk("byp_rbusy", {31'b0, rbusy[0]}, 32'h0);
`else
      chk("nobyp_rdata", rdata[0], 32'h0);
      chk("nobyp_rbusy", {31'b0, rbusy[0]}, 32'h1);
`endif
      @(negedge clk);
      idle();
      #1;
      chk("r3_after", rdata[0], 32'hDEADBEEF);
      chk("r3_rel", {31'b0, rbusy[0]}, 32'h0);

      // asynchronous reset between edges
      @(negedge clk);
      iss_valid = 1'b1;
      iss_rd    = 5'd4;
      @(negedge clk);
      idle();
      wen      = 2'b10;
      waddr[1] = 5'd4;
      wdata[1] = 32'h00001234;
      iss_valid = 1'b1;
      iss_rd    = 5'd4;
      @(negedge clk);
      idle();
      iss_valid = 1'b1;
      iss_rd    = 5'd4;
      raddr[0] = 5'd4;
      raddr[1] = 5'd4;
      #1;
      chk("r4_val", rdata[0], 32'h00001234);
      chk("r4_busy", {30'b0, rbusy}, 32'h3);
      chk("r4_stall", {31'b0, iss_stall}, 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_rdata0", rdata[0], 32'h0);
      chk("arst_rdata1", rdata[1], 32'h0);
      chk("arst_rbusy", {30'b0, rbusy}, 32'h0);
      chk("arst_stall", {31'b0, iss_stall}, 32'h0);
      chk("arst_err", {31'b0, err_wconflict}, 32'h0);
      wen      = 2'b01;
      waddr[0] = 5'd4;
      wdata[0] = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle();
      @(negedge clk);
      #1;
      chk("arst_write_dropped", rdata[0], 32'h0);
      chk("arst_busy_after", {30'b0, rbusy}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
